// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder.
//   UART_DATA_W    : width of one transmitted byte.
//   feeder_state_e : frame sequencer states (IDLE -> START -> WAIT -> IDLE).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a queued byte
    START = 2'd1,  // start request held high
    WAIT  = 2'd2   // frame spacing after the start pulse
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter.
// A write while full is dropped (contents untouched) and latches the sticky
// overflow flag, even if a read happens in the same cycle.
//   clk, reset        : clock, synchronous active-high reset
//   wr_en, wr_data    : push request and data
//   rd_en, rd_data    : pop request; rd_data shows the head entry
//   full, empty       : registered occupancy flags
//   count             : entries held
//   overflow          : sticky, set by a dropped write, cleared by reset
module uart_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = wr_en && !full_q;
  assign rd_ok = rd_en && !empty_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count define which entries
  // are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      // Pointers are exactly AW bits, so DEPTH being a power of two makes
      // the increment wrap modulo DEPTH for free.
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_COUNT);
      empty_q <= (count_d == '0);
      if (wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering front end for the UART transmitter. Host writes queue in a
// FIFO; a three-state sequencer pops one byte per frame, raises o_Txstart for
// START_HOLD cycles and spaces frames FRAME_CYCLES apart (plus one IDLE cycle
// between back-to-back frames).
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_wr_en, i_wr_data   : host write port, one byte per cycle
//   o_full, o_empty      : FIFO occupancy flags (registered)
//   o_count              : bytes queued, excluding the byte in flight
//   o_Txstart            : start request to the transmitter
//   o_Txdatain           : byte being sent; changes only on a pop
//   o_busy               : sequencer not in IDLE
//   o_overflow           : sticky dropped-write indicator
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int START_HOLD   = 10,
  parameter int FRAME_CYCLES = 104
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr_en,
  input  logic [UART_DATA_W-1:0]  i_wr_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_Txstart,
  output logic [UART_DATA_W-1:0]  o_Txdatain,
  output logic                    o_busy,
  output logic                    o_overflow
);

  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(START_HOLD);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES);

  feeder_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   txstart_q, txstart_d;
  logic [UART_DATA_W-1:0] txdata_q, txdata_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;
  logic                   fifo_empty;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .wr_en    (i_wr_en),
    .wr_data  (i_wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (o_full),
    .empty    (fifo_empty),
    .count    (o_count),
    .overflow (o_overflow)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      txstart_q <= 1'b0;
      txdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txstart_q <= txstart_d;
      txdata_q  <= txdata_d;
    end
  end

  // The counter holds the number of cycles since the start rise, so the
  // comparisons below fire on the edge that completes START_HOLD high cycles
  // and FRAME_CYCLES frame cycles respectively.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    txstart_d = txstart_q;
    txdata_d  = txdata_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          txdata_d  = head;
          txstart_d = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          txstart_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        txstart_d = 1'b0;
      end
    endcase
  end

  assign o_empty    = fifo_empty;
  assign o_Txstart  = txstart_q;
  assign o_Txdatain = txdata_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH        = 8;
  localparam int START_HOLD   = 10;
  localparam int FRAME_CYCLES = 104;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_full, o_empty, o_Txstart, o_busy, o_overflow;
  logic [3:0] o_count;
  logic [7:0] o_Txdatain;

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .START_HOLD   (START_HOLD),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_Txstart  (o_Txstart),
    .o_Txdatain (o_Txdatain),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int total = 0;
  int bad   = 0;

  // Bytes seen at every rising edge of o_Txstart, in order.
  logic [7:0] rx_q[$];
  logic       prev_start = 1'b0;
  always @(posedge i_clk) begin
    #1;
    if (o_Txstart && !prev_start) rx_q.push_back(o_Txdatain);
    prev_start = o_Txstart;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic [3:0] cnt;
    logic       empty;
    logic       full;
    logic       start;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_wr_en = 1'b0;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while ((o_busy || !o_empty) && w < 600) begin
      step();
      w++;
    end
    check({nm, " idle reached"}, 32'(o_busy), 32'd0);
  endtask

  // Wait (bounded) for a start pulse, then measure its width and data.
  task automatic frame_check(input logic [7:0] d, input string nm, output int rise);
    int w = 0;
    int hi = 0;
    int bad_data = 0;
    while (!o_Txstart && w < 400) begin
      step();
      w++;
    end
    check({nm, " start seen"}, 32'(o_Txstart), 32'd1);
    rise = cyc;
    check({nm, " data"}, 32'(o_Txdatain), 32'(d));
    while (o_Txstart && hi < 50) begin
      if (o_Txdatain !== d) bad_data++;
      hi++;
      step();
    end
    check({nm, " hold"}, 32'(hi), 32'(START_HOLD));
    check({nm, " data stable"}, 32'(bad_data), 32'd0);
  endtask

  initial begin
    int r, r_prev, w;
    logic [7:0] exp_q[$];

    // Burst vectors applied straight after the single-byte frame, so the
    // transmit data still holds 8'h95 at first.
    vecs[0] = '{1'b1, 8'hB9, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h95};
    vecs[1] = '{1'b1, 8'hC3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB9};
    vecs[2] = '{1'b1, 8'hCC, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB9};
    for (int i = 3; i <= 10; i++) vecs[i] = '{1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB9};
    vecs[11] = '{1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB9};
    vecs[12] = '{1'b0, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB9};

    // ---- reset values and single-byte frame ----
    do_reset();
    check("rst txstart", 32'(o_Txstart), 32'd0);
    check("rst txdata", 32'(o_Txdatain), 32'h00);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst overflow", 32'(o_overflow), 32'd0);
    check("rst count", 32'(o_count), 32'd0);
    check("rst empty", 32'(o_empty), 32'd1);
    check("rst full", 32'(o_full), 32'd0);

    i_wr_en = 1'b1;
    i_wr_data = 8'h95;
    step();
    i_wr_en = 1'b0;
    check("single count after write", 32'(o_count), 32'd1);
    check("single txstart after write", 32'(o_Txstart), 32'd0);
    step();
    check("single txstart next edge", 32'(o_Txstart), 32'd1);
    check("single count after pop", 32'(o_count), 32'd0);
    check("single empty after pop", 32'(o_empty), 32'd1);
    frame_check(8'h95, "single", r);
    w = 0;
    while (o_busy && w < 200) begin
      step();
      w++;
    end
    check("single busy fall delay", 32'(cyc - r), 32'(FRAME_CYCLES));
    check("single data held in idle", 32'(o_Txdatain), 32'h95);

    // ---- burst of three ----
    rx_q.delete();
    for (int i = 0; i < 13; i++) begin
      i_wr_en = vecs[i].wr_en;
      i_wr_data = vecs[i].wr_data;
      step();
      if (i == 1) r_prev = cyc;
      check($sformatf("vec%0d count", i), 32'(o_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d empty", i), 32'(o_empty), 32'(vecs[i].empty));
      check($sformatf("vec%0d full", i), 32'(o_full), 32'(vecs[i].full));
      check($sformatf("vec%0d txstart", i), 32'(o_Txstart), 32'(vecs[i].start));
      check($sformatf("vec%0d busy", i), 32'(o_busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d txdata", i), 32'(o_Txdatain), 32'(vecs[i].data));
    end
    i_wr_en = 1'b0;
    frame_check(8'hC3, "burst2", r);
    check("burst2 gap", 32'(r - r_prev), 32'(FRAME_CYCLES + 1));
    check("burst2 count", 32'(o_count), 32'd1);
    r_prev = r;
    frame_check(8'hCC, "burst3", r);
    check("burst3 gap", 32'(r - r_prev), 32'(FRAME_CYCLES + 1));
    check("burst3 count", 32'(o_count), 32'd0);
    wait_idle("burst");
    check("burst frames", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("burst order 0", 32'(rx_q[0]), 32'hB9);
      check("burst order 1", 32'(rx_q[1]), 32'hC3);
      check("burst order 2", 32'(rx_q[2]), 32'hCC);
    end

    // ---- overflow, including a full write in the same cycle as a pop ----
    do_reset();
    rx_q.delete();
    r_prev = 0;
    for (int k = 0; k < 10; k++) begin
      i_wr_en = 1'b1;
      i_wr_data = 8'(8'h10 + k);
      step();
      if (k == 1) r_prev = cyc;
      if (k == 7) begin
        check("ovf full at 7", 32'(o_full), 32'd0);
        check("ovf count at 7", 32'(o_count), 32'd7);
      end
      if (k == 8) begin
        check("ovf full at 8", 32'(o_full), 32'd1);
        check("ovf count at 8", 32'(o_count), 32'd8);
        check("ovf flag before drop", 32'(o_overflow), 32'd0);
      end
      if (k == 9) begin
        check("ovf flag after drop", 32'(o_overflow), 32'd1);
        check("ovf count after drop", 32'(o_count), 32'd8);
        check("ovf full after drop", 32'(o_full), 32'd1);
      end
    end
    i_wr_en = 1'b0;
    while (cyc < r_prev + FRAME_CYCLES) step();
    check("ovf idle before pop", 32'(o_busy), 32'd0);
    check("ovf full before pop", 32'(o_full), 32'd1);
    i_wr_en = 1'b1;
    i_wr_data = 8'hEE;
    step();
    i_wr_en = 1'b0;
    check("popfull txstart", 32'(o_Txstart), 32'd1);
    check("popfull count", 32'(o_count), 32'd7);
    check("popfull overflow", 32'(o_overflow), 32'd1);
    check("popfull full", 32'(o_full), 32'd0);
    frame_check(8'h11, "ovf1", r);
    check("ovf1 gap", 32'(r - r_prev), 32'(FRAME_CYCLES + 1));
    for (int j = 2; j <= 8; j++) frame_check(8'(8'h10 + j), $sformatf("ovf%0d", j), r);
    wait_idle("ovf");
    for (int j = 0; j < 150; j++) step();
    check("ovf frames", 32'(rx_q.size()), 32'd9);
    for (int j = 0; j < 9 && j < rx_q.size(); j++)
      check($sformatf("ovf order %0d", j), 32'(rx_q[j]), 32'(8'h10 + j));
    check("ovf sticky", 32'(o_overflow), 32'd1);

    // ---- reset in the middle of a frame ----
    do_reset();
    check("reset clears overflow", 32'(o_overflow), 32'd0);
    rx_q.delete();
    for (int k = 0; k < 4; k++) begin
      i_wr_en = 1'b1;
      i_wr_data = 8'(8'hA1 + k);
      step();
      if (k == 1) r_prev = cyc;
    end
    i_wr_en = 1'b0;
    while (cyc < r_prev + 4) step();
    check("midrst setup count", 32'(o_count), 32'd3);
    check("midrst setup txstart", 32'(o_Txstart), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("midrst txstart", 32'(o_Txstart), 32'd0);
    check("midrst count", 32'(o_count), 32'd0);
    check("midrst empty", 32'(o_empty), 32'd1);
    check("midrst txdata", 32'(o_Txdatain), 32'h00);
    check("midrst busy", 32'(o_busy), 32'd0);
    for (int j = 0; j < 250; j++) step();
    check("midrst no further frames", 32'(rx_q.size()), 32'd1);
    check("midrst still idle", 32'(o_busy), 32'd0);

    // ---- pointer wrap: 20 bytes in bursts of 4 ----
    rx_q.delete();
    for (int b = 0; b < 5; b++) begin
      wait_idle($sformatf("wrap burst %0d", b));
      for (int j = 0; j < 4; j++) begin
        i_wr_en = 1'b1;
        i_wr_data = 8'((b * 4 + j) * 37 + 5);
        exp_q.push_back(i_wr_data);
        step();
      end
      i_wr_en = 1'b0;
    end
    wait_idle("wrap drain");
    for (int j = 0; j < 20; j++) step();
    check("wrap frames", 32'(rx_q.size()), 32'd20);
    for (int j = 0; j < 20 && j < rx_q.size(); j++)
      check($sformatf("wrap order %0d", j), 32'(rx_q[j]), 32'(exp_q[j]));
    check("wrap no overflow", 32'(o_overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
